// File: rtl/si5340_reg_sequencer.sv
// Expands paged Si5340 register writes into I2C byte-controller commands:
// an optional page select, the register write, and an optional read-back verify.
module si5340_reg_sequencer #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h74,
    parameter bit          VERIFY     = 1'b1,
    parameter logic [15:0] TIMEOUT    = 16'd50000,
    parameter int          DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [15:0]           req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o,
    output logic                  start,
    output logic                  stop,
    output logic                  write,
    output logic                  read,
    output logic                  ack_in,
    output logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] dout,
    input  logic                  cmd_ack
);

    // Request handshake: a request transfers on a clk_i edge where
    // req_valid_i & req_ready_o; req_ready_o is high only while IDLE.
    typedef enum logic [3:0] {
        IDLE, PG_DEV, PG_REG, PG_DATA, WR_DEV, WR_REG, WR_DATA,
        RB_DEV, RB_REG, RB_RDEV, RB_READ, CHECK, RESP
    } state_t;

    localparam logic [DATA_WIDTH-1:0] DEV_WR   = DATA_WIDTH'({SLAVE_ADDR, 1'b0});
    localparam logic [DATA_WIDTH-1:0] DEV_RD   = DATA_WIDTH'({SLAVE_ADDR, 1'b1});
    localparam logic [DATA_WIDTH-1:0] PAGE_REG = DATA_WIDTH'(8'h01);
    localparam logic [1:0]            CODE_TMO = 2'b01;
    localparam logic [1:0]            CODE_VFY = 2'b10;

    state_t state, next_state;

    logic [7:0]            page_q, reg_q, cache_page;
    logic [DATA_WIDTH-1:0] data_q, rd_q;
    logic                  cache_valid;
    logic [15:0]           tmo_cnt;
    logic                  accept, page_miss, is_cmd, timeout_hit, mismatch;

    logic                  start_d, stop_d, write_d, read_d, ack_in_d;
    logic [DATA_WIDTH-1:0] din_d;
    logic                  ready_d, busy_d, done_d, err_d;
    logic [1:0]            err_code_d;

    assign accept      = req_valid_i & req_ready_o;
    assign page_miss   = !cache_valid || (req_addr_i[15:8] != cache_page);
    assign is_cmd      = (state inside {PG_DEV, PG_REG, PG_DATA, WR_DEV, WR_REG, WR_DATA,
                                        RB_DEV, RB_REG, RB_RDEV, RB_READ});
    // A cmd_ack arriving in the same cycle as the limit wins over the timeout.
    assign timeout_hit = is_cmd && !cmd_ack && (tmo_cnt == TIMEOUT);
    assign mismatch    = VERIFY && (rd_q != data_q);

    // State and registered outputs; every output is a registered decode of
    // next_state so commands stay stable until cmd_ack is sampled.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= 2'b00;
            start       <= 1'b0;
            stop        <= 1'b0;
            write       <= 1'b0;
            read        <= 1'b0;
            ack_in      <= 1'b0;
            din         <= '0;
        end else begin
            state       <= next_state;
            req_ready_o <= ready_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
            err_o       <= err_d;
            err_code_o  <= err_code_d;
            start       <= start_d;
            stop        <= stop_d;
            write       <= write_d;
            read        <= read_d;
            ack_in      <= ack_in_d;
            din         <= din_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = page_miss ? PG_DEV : WR_DEV;
                end
            end
            PG_DEV:  if (cmd_ack) next_state = PG_REG;  else if (timeout_hit) next_state = RESP;
            PG_REG:  if (cmd_ack) next_state = PG_DATA; else if (timeout_hit) next_state = RESP;
            PG_DATA: if (cmd_ack) next_state = WR_DEV;  else if (timeout_hit) next_state = RESP;
            WR_DEV:  if (cmd_ack) next_state = WR_REG;  else if (timeout_hit) next_state = RESP;
            WR_REG:  if (cmd_ack) next_state = WR_DATA; else if (timeout_hit) next_state = RESP;
            WR_DATA: begin
                if (cmd_ack) begin
                    next_state = VERIFY ? RB_DEV : CHECK;
                end else if (timeout_hit) begin
                    next_state = RESP;
                end
            end
            RB_DEV:  if (cmd_ack) next_state = RB_REG;  else if (timeout_hit) next_state = RESP;
            RB_REG:  if (cmd_ack) next_state = RB_RDEV; else if (timeout_hit) next_state = RESP;
            RB_RDEV: if (cmd_ack) next_state = RB_READ; else if (timeout_hit) next_state = RESP;
            RB_READ: if (cmd_ack) next_state = CHECK;   else if (timeout_hit) next_state = RESP;
            CHECK:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        start_d  = 1'b0;
        stop_d   = 1'b0;
        write_d  = 1'b0;
        read_d   = 1'b0;
        ack_in_d = 1'b0;
        din_d    = '0;
        case (next_state)
            PG_DEV, WR_DEV, RB_DEV: begin
                start_d = 1'b1;
                write_d = 1'b1;
                din_d   = DEV_WR;
            end
            PG_REG: begin
                write_d = 1'b1;
                din_d   = PAGE_REG;
            end
            PG_DATA: begin
                write_d = 1'b1;
                stop_d  = 1'b1;
                din_d   = DATA_WIDTH'(page_q);
            end
            WR_REG, RB_REG: begin
                write_d = 1'b1;
                din_d   = DATA_WIDTH'(reg_q);
            end
            WR_DATA: begin
                write_d = 1'b1;
                stop_d  = 1'b1;
                din_d   = data_q;
            end
            RB_RDEV: begin
                start_d = 1'b1;
                write_d = 1'b1;
                din_d   = DEV_RD;
            end
            RB_READ: begin
                read_d   = 1'b1;
                stop_d   = 1'b1;
                ack_in_d = 1'b1;
            end
            default: ;
        endcase

        ready_d    = (next_state == IDLE);
        busy_d     = (next_state != IDLE);
        err_d      = (next_state == RESP) && (timeout_hit || (state == CHECK && mismatch));
        done_d     = (next_state == RESP) && !err_d;
        err_code_d = err_code_o;
        if (err_d) begin
            err_code_d = timeout_hit ? CODE_TMO : CODE_VFY;
        end
    end

    // Request latch, page cache, read-back capture and per-command timer.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            page_q      <= 8'h00;
            reg_q       <= 8'h00;
            data_q      <= '0;
            rd_q        <= '0;
            cache_valid <= 1'b0;
            cache_page  <= 8'h00;
            tmo_cnt     <= 16'd0;
        end else begin
            if (accept) begin
                page_q <= req_addr_i[15:8];
                reg_q  <= req_addr_i[7:0];
                data_q <= req_data_i;
            end
            if (state == PG_DATA && cmd_ack) begin
                cache_valid <= 1'b1;
                cache_page  <= page_q;
            end
            if (timeout_hit) begin
                cache_valid <= 1'b0;
            end
            if (state == RB_READ && cmd_ack) begin
                rd_q <= dout;
            end
            // Counts the cycles the current command has been presented, starting at 1.
            if (next_state != state) begin
                tmo_cnt <= 16'd1;
            end else if (is_cmd) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/si5340_reg_sequencer.md
Name: si5340_reg_sequencer

Overview:
- Master-side sequencer for the byte-level I2C command controller (start/stop/read/write/ack_in/din/dout/cmd_ack command set).
- Accepts paged Si5340 register-write requests over a valid/ready stream and expands each into byte commands:
  - page-select write to register 0x01, issued only when the page changes;
  - register write;
  - optional read-back verify.
- Sits between the configuration ROM walker and the I2C byte controller.

Parameters:
- SLAVE_ADDR, 7'h74, 7-bit Si5340 I2C address.
- VERIFY, 1, when 1 every write is followed by read-back and compare.
- TIMEOUT, 16'd50000, max clk_i cycles to wait for cmd_ack per command.
- DATA_WIDTH, 8, I2C byte width (cfg_pkg value).

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  synchronous reset, active-low
- req_valid_i  in  1  register write request valid
- req_ready_o  out  1  sequencer accepts request
- req_addr_i  in  16  [15:8] page, [7:0] register
- req_data_i  in  DATA_WIDTH  value to write
- busy_o  out  1  transaction in progress
- done_o  out  1  one-cycle pulse, request completed OK
- err_o  out  1  one-cycle pulse, request failed
- err_code_o  out  2  01 timeout, 10 verify mismatch; valid with err_o, holds until next err_o
- start  out  1  I2C command: generate START before byte
- stop  out  1  I2C command: generate STOP after byte
- write  out  1  I2C command: transmit din
- read  out  1  I2C command: receive byte into dout
- ack_in  out  1  ACK bit to send after read (1 = NACK)
- din  out  DATA_WIDTH  byte to transmit
- dout  in  DATA_WIDTH  received byte, valid when cmd_ack follows a read
- cmd_ack  in  1  one-cycle command-complete pulse

Behaviour:
- Reset (rstn_i low at clk_i edge):
  - All outputs 0 except req_ready_o = 0; err_code_o = 00.
  - Page cache invalid; state IDLE.
  - req_ready_o rises the first cycle after reset release.
  - Reset mid-transaction aborts immediately; no STOP is issued.
- Handshake:
  - Request accepted on a cycle where req_valid_i & req_ready_o.
  - req_ready_o = 1 only in IDLE.
  - Address and data are latched at acceptance.
  - busy_o = 1 from the cycle after acceptance until the cycle done_o/err_o pulses.
- Command protocol:
  - Each command bit and din are registered and held stable until cmd_ack is sampled high.
  - The next command may be presented the following cycle; otherwise all command bits go to 0.
  - Exactly one of write/read is high per command.
- State sequence after acceptance:
  - If the cache is invalid or page ≠ cached page:
    - PG_DEV: start+write, din = {SLAVE_ADDR,0}
    - PG_REG: write, din = 0x01
    - PG_DATA: write+stop, din = page
    - Cache is updated at PG_DATA cmd_ack.
  - WR_DEV: start+write, din = {SLAVE_ADDR,0}
  - WR_REG: write, din = reg
  - WR_DATA: write+stop, din = data
  - If VERIFY:
    - RB_DEV: start+write, {SLAVE_ADDR,0}
    - RB_REG: write, reg
    - RB_RDEV: start+write, {SLAVE_ADDR,1}
    - RB_READ: read+stop, ack_in = 1
    - dout is latched at RB_READ cmd_ack.
  - CHECK: pulse done_o if dout matches data, else err_o with code 10. Page cache stays valid either way.
  - Return to IDLE; req_ready_o = 1 the next cycle.
- Timeout:
  - A 16-bit counter resets on each new command and counts while waiting for cmd_ack.
  - When it reaches TIMEOUT without cmd_ack:
    - all command bits drop to 0;
    - err_o pulses with code 01;
    - page cache is invalidated;
    - state returns to IDLE.
  - cmd_ack in the same cycle the counter hits TIMEOUT counts as success.
- Stray cmd_ack in IDLE is ignored.
- Latency without page change, VERIFY = 0, cmd_ack after 1 cycle:
  - 3 commands, each 2 cycles (present + ack cycle);
  - done_o at acceptance + 8 cycles.

Test Plan:
- Reset, then request addr 0x0B24, data 0x5A, VERIFY = 0, bench acks each command 3 cycles later → din sequence E8 (start), 01, 0B (stop), E8 (start), 24, 5A (stop); one done_o; err_o never high.
- Second request addr 0x0B30, data 0x11 → no page write; din sequence E8, 30, 11; done_o once.
- VERIFY = 1, request 0x0C10 data 0xA5, bench returns dout = 0xA5 → page write plus write sequence, then E8, 10, E9, read with ack_in = 1 and stop → done_o. Repeat with dout = 0xA4 → err_o, err_code_o = 10.
- TIMEOUT = 100, bench never asserts cmd_ack → start/write held 100 cycles, then command bits = 0, err_o with code 01. Next request to the same page re-issues the page write.
- Reset asserted during WR_REG → all outputs 0 next cycle. Next request performs the page write first (cache invalid).
- req_valid_i held high with back-to-back requests → each accepted only in IDLE; req_ready_o low while busy_o = 1; no request dropped or duplicated.
